// File: rtl/wimax_block_interleaver.sv
// Ping-pong WiMAX block interleaver: bits are written at their permuted address, then read out in order.
// Optional INTLV_BYPASS_EN adds a bypass port that selects natural write order per block.
module wimax_block_interleaver #(
  parameter int NSC  = 96,
  parameter int D    = 16,
  parameter int IDXW = $clog2(NSC*6)
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [1:0]      mode,
  input  logic            valid_in,
  input  logic            data_in,
  output logic            ready_out,
  output logic            valid_out,
  output logic            data_out,
  output logic [IDXW-1:0] out_index,
  output logic            out_last,
  input  logic            ready_in
`ifdef INTLV_BYPASS_EN
  ,
  input  logic            bypass
`endif
);

  localparam int DEPTH = NSC*6;
  localparam int XW    = IDXW + 4;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  function automatic logic [XW-1:0] ncbps_of(input logic [1:0] md);
    case (md)
      2'd1:    ncbps_of = XW'(NSC*4);
      2'd2:    ncbps_of = XW'(NSC*6);
      default: ncbps_of = XW'(NSC*2);
    endcase
  endfunction

  function automatic logic [IDXW-1:0] perm_addr(input logic [IDXW-1:0] k,
                                                input logic [1:0]      md);
    logic [XW-1:0] ncbps, cols, kx, kmod, m, u, j;
    ncbps = ncbps_of(md);
    cols  = ncbps / XW'(D);
    kx    = XW'(k);
    kmod  = kx % XW'(D);
    m     = cols * kmod + kx / XW'(D);
    // floor(D*m/Ncbps) collapses to k mod D since k/D < Ncbps/D (D divides Ncbps)
    u     = m + ncbps - kmod;
    case (md)
      2'd1:    j = {m[XW-1:1], u[0]};
      2'd2:    j = (m / XW'(3)) * XW'(3) + (u % XW'(3));
      default: j = m;
    endcase
    perm_addr = IDXW'(j);
  endfunction

  bank_state_e      st_q    [2];
  logic [1:0]       bmode_q [2];
  logic [DEPTH-1:0] mem_q   [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [IDXW-1:0]  k_q, r_q;
  logic [1:0]       blk_mode_q;
`ifdef INTLV_BYPASS_EN
  logic             blk_byp_q;
  logic             wr_byp;
`endif

  logic [1:0]       mode_n, wr_mode;
  logic [XW-1:0]    wr_ncbps, rd_ncbps;
  logic [IDXW-1:0]  wr_addr;
  logic             accept, wr_last, xfer, rd_last;

  always_comb begin
    mode_n    = (mode == 2'd3) ? 2'd0 : mode;
    wr_mode   = (k_q == '0) ? mode_n : blk_mode_q;
    wr_ncbps  = ncbps_of(wr_mode);
    ready_out = (st_q[wr_ptr_q] == BANK_EMPTY) || (st_q[wr_ptr_q] == BANK_FILLING);
    accept    = valid_in && ready_out;
    wr_last   = (XW'(k_q) == wr_ncbps - XW'(1));
    wr_addr   = perm_addr(k_q, wr_mode);
`ifdef INTLV_BYPASS_EN
    wr_byp    = (k_q == '0) ? bypass : blk_byp_q;
    if (wr_byp) wr_addr = k_q;
`endif
    rd_ncbps  = ncbps_of(bmode_q[rd_ptr_q]);
    valid_out = (st_q[rd_ptr_q] == BANK_FULL) || (st_q[rd_ptr_q] == BANK_DRAINING);
    rd_last   = (XW'(r_q) == rd_ncbps - XW'(1));
    xfer      = valid_out && ready_in;
    data_out  = valid_out && mem_q[rd_ptr_q][r_q];
    out_index = r_q;
    out_last  = valid_out && rd_last;
  end

  // Bank/pointer control; write and read sides always touch different banks
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st_q[0]    <= BANK_EMPTY;
      st_q[1]    <= BANK_EMPTY;
      bmode_q[0] <= '0;
      bmode_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      k_q        <= '0;
      r_q        <= '0;
      blk_mode_q <= '0;
`ifdef INTLV_BYPASS_EN
      blk_byp_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (k_q == '0) begin
          blk_mode_q        <= mode_n;
          bmode_q[wr_ptr_q] <= mode_n;
`ifdef INTLV_BYPASS_EN
          blk_byp_q         <= bypass;
`endif
        end
        if (wr_last) begin
          st_q[wr_ptr_q] <= BANK_FULL;
          k_q            <= '0;
          wr_ptr_q       <= ~wr_ptr_q;
        end else begin
          st_q[wr_ptr_q] <= BANK_FILLING;
          k_q            <= k_q + IDXW'(1);
        end
      end
      if (xfer) begin
        if (rd_last) begin
          st_q[rd_ptr_q] <= BANK_EMPTY;
          r_q            <= '0;
          rd_ptr_q       <= ~rd_ptr_q;
        end else begin
          st_q[rd_ptr_q] <= BANK_DRAINING;
          r_q            <= r_q + IDXW'(1);
        end
      end
    end
  end

  // Bit storage carries no reset: every address of a block is rewritten before it is read
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q][wr_addr] <= data_in;
  end

endmodule
